conn_table_reader: RTL

Transmit-side reader for the connection table that the RX-side searcher fills. The searcher maps a 4-tuple to a connection ID; this block maps a connection ID back to its stored MAC/IP/port tuple and valid bit, for the TX header builder. It owns the RAM read port (address/q), keeps a one-entry last-ID cache, and takes invalidate notifications from the searcher's write/delete path.

---
 rtl/conn_pkg.sv | 54 +++++
 rtl/conn_entry_cache.sv | 43 ++++
 rtl/conn_table_reader.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/conn_pkg.sv
// Shared connection-table definitions: entry layout, error codes, reader FSM states.
package conn_pkg;

  localparam int ENTRY_W = 145;
  localparam int ID_W    = 8;

  localparam int MAC_SRC_HI  = 144;
  localparam int MAC_SRC_LO  = 121;
  localparam int MAC_DST_HI  = 120;
  localparam int MAC_DST_LO  = 97;
  localparam int IP_SRC_HI   = 96;
  localparam int IP_SRC_LO   = 65;
  localparam int IP_DST_HI   = 64;
  localparam int IP_DST_LO   = 33;
  localparam int PORT_SRC_HI = 32;
  localparam int PORT_SRC_LO = 17;
  localparam int PORT_DST_HI = 16;
  localparam int PORT_DST_LO = 1;
  localparam int VALID_BIT   = 0;

  localparam logic [7:0] ERR_OK      = 8'h00;
  localparam logic [7:0] ERR_INVALID = 8'h04;
  localparam logic [7:0] ERR_RANGE   = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RANGE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_RESP  = 3'd4
  } conn_state_t;

  typedef struct packed {
    logic [23:0] mac_src;
    logic [23:0] mac_dst;
    logic [31:0] ip_src;
    logic [31:0] ip_dst;
    logic [15:0] port_src;
    logic [15:0] port_dst;
  } conn_tuple_t;

  // Unpack the stored tuple fields of a RAM word (valid bit excluded).
  function automatic conn_tuple_t entry_tuple(input logic [ENTRY_W-1:0] entry);
    conn_tuple_t t;
    t.mac_src  = entry[MAC_SRC_HI:MAC_SRC_LO];
    t.mac_dst  = entry[MAC_DST_HI:MAC_DST_LO];
    t.ip_src   = entry[IP_SRC_HI:IP_SRC_LO];
    t.ip_dst   = entry[IP_DST_HI:IP_DST_LO];
    t.port_src = entry[PORT_SRC_HI:PORT_SRC_LO];
    t.port_dst = entry[PORT_DST_HI:PORT_DST_LO];
    return t;
  endfunction

endpackage

// File: rtl/conn_entry_cache.sv
// Single-entry last-ID cache: tag/tuple register with lookup, load and invalidate.
module conn_entry_cache
  import conn_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ID_W-1:0] lookup_id,
  output logic            hit,
  output conn_tuple_t     hit_tuple,
  input  logic            load,
  input  logic [ID_W-1:0] load_id,
  input  conn_tuple_t     load_tuple,
  input  logic            inv,
  input  logic [ID_W-1:0] inv_id
);

  logic            vld_q;
  logic [ID_W-1:0] tag_q;
  conn_tuple_t     data_q;

  // Entry valid: a load (re)arms it, a write/delete of the cached ID drops it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
    end else if (load) begin
      vld_q <= 1'b1;
    end else if (inv && (inv_id == tag_q)) begin
      vld_q <= 1'b0;
    end
  end

  // Tag and tuple storage; contents only matter while vld_q is set.
  always_ff @(posedge clk) begin
    if (load) begin
      tag_q  <= load_id;
      data_q <= load_tuple;
    end
  end

  assign hit       = vld_q && (tag_q == lookup_id);
  assign hit_tuple = data_q;

endmodule

// File: rtl/conn_table_reader.sv
// TX-side connection table reader: maps a connection ID to its stored tuple,
// fronted by a one-entry cache kept coherent with searcher write/delete events.
module conn_table_reader
  import conn_pkg::*;
#(
  parameter int MAX_CONN   = 128,
  parameter int RD_LATENCY = 2
) (
  input  logic               cr_clk,
  input  logic               cr_rst,
  input  logic               cr_req_valid,
  output logic               cr_req_ready,
  input  logic [ID_W-1:0]    cr_id_in,
  input  logic               cr_inv,
  input  logic [ID_W-1:0]    cr_inv_id,
  output logic [ID_W-1:0]    cr_ram_addr,
  input  logic [ENTRY_W-1:0] cr_ram_q,
  output logic               cr_done,
  output logic [7:0]         cr_error,
  output logic [23:0]        cr_mac_src,
  output logic [23:0]        cr_mac_dst,
  output logic [31:0]        cr_ip_src,
  output logic [31:0]        cr_ip_dst,
  output logic [15:0]        cr_port_src,
  output logic [15:0]        cr_port_dst
);

  localparam logic [1:0] WAIT_LOAD = 2'(RD_LATENCY - 1);

  conn_state_t     state_q, state_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] addr_q, addr_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [7:0]      err_q, err_d;
  conn_tuple_t     tup_q, tup_d;
  logic            inv_pend_q, inv_pend_d;
  logic            rdy_q;
  logic            cache_hit, cache_load;
  conn_tuple_t     cache_tuple, ram_tuple;
  logic            inv_cur, id_oor;

  // A write/delete of the ID currently being served.
  assign inv_cur   = cr_inv && (cr_inv_id == id_q);
  assign id_oor    = {{(32-ID_W){1'b0}}, id_q} >= 32'(MAX_CONN);
  assign ram_tuple = entry_tuple(cr_ram_q);

  conn_entry_cache u_cache (
    .clk        (cr_clk),
    .rst_n      (cr_rst),
    .lookup_id  (id_q),
    .hit        (cache_hit),
    .hit_tuple  (cache_tuple),
    .load       (cache_load),
    .load_id    (id_q),
    .load_tuple (ram_tuple),
    .inv        (cr_inv),
    .inv_id     (cr_inv_id)
  );

  // Lookup sequencing: range check, cache probe, RAM read wait, result capture.
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    tup_d      = tup_q;
    inv_pend_d = inv_pend_q;
    cache_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cr_req_valid && rdy_q) begin
          id_d    = cr_id_in;
          state_d = ST_RANGE;
        end
      end
      ST_RANGE: begin
        if (id_oor) begin
          err_d   = ERR_RANGE;
          tup_d   = '0;
          state_d = ST_RESP;
        end else if (cache_hit && !inv_cur) begin
          // A same-cycle invalidate means the cached copy may be stale.
          err_d   = ERR_OK;
          tup_d   = cache_tuple;
          state_d = ST_RESP;
        end else begin
          addr_d     = id_q;
          cnt_d      = WAIT_LOAD;
          inv_pend_d = 1'b0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (inv_cur) inv_pend_d = 1'b1;
        if (cnt_q == 2'd0) state_d = ST_CHECK;
        else               cnt_d   = cnt_q - 2'd1;
      end
      ST_CHECK: begin
        if (cr_ram_q[VALID_BIT]) begin
          err_d      = ERR_OK;
          tup_d      = ram_tuple;
          // Data read while the entry was being rewritten is returned but not cached.
          cache_load = !inv_pend_q && !inv_cur;
        end else begin
          err_d = ERR_INVALID;
          tup_d = '0;
        end
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request context and held result registers.
  always_ff @(posedge cr_clk or negedge cr_rst) begin
    if (!cr_rst) begin
      state_q    <= ST_IDLE;
      id_q       <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      err_q      <= ERR_OK;
      tup_q      <= '0;
      inv_pend_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      tup_q      <= tup_d;
      inv_pend_q <= inv_pend_d;
      rdy_q      <= (state_d == ST_IDLE);
    end
  end

  assign cr_req_ready = rdy_q;
  assign cr_done      = (state_q == ST_RESP);
  assign cr_ram_addr  = addr_q;
  assign cr_error     = err_q;
  assign cr_mac_src   = tup_q.mac_src;
  assign cr_mac_dst   = tup_q.mac_dst;
  assign cr_ip_src    = tup_q.ip_src;
  assign cr_ip_dst    = tup_q.ip_dst;
  assign cr_port_src  = tup_q.port_src;
  assign cr_port_dst  = tup_q.port_dst;

endmodule
